branch_ctrl: RTL
================

// Module: branch_ctrl
// PURPOSE
//  Conditional-branch resolver downstream of the condition-code register.
//  - Accepts one branch request at a time.
//  - Evaluates it against the flags, forwarding ALU flags written in the same cycle.
//  - Redirects the PC and flushes the front end for a fixed number of cycles.
//  - Pulses a one-hot flag-clear back to the flag register on a taken conditional.
//  - Flag bit order: [0]=Z [1]=N [2]=C [3]=V.
// PARAMETERS
//  ADDR_W        8   width of branch target / PC
//  FLUSH_CYCLES  2   cycles flush is held after a taken branch (legal range 1..15)
//  CLR_ON_TAKEN  1   1: taken conditional branch pulses flag_clr for the tested flag; 0: flag_clr stays 0
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  ccr_in       in   4       current flag register contents
//  alu_flags    in   4       flags the ALU is writing this cycle, same bit order
//  alu_flag_en  in   1       alu_flags are being written this cycle
//  br_valid     in   1       branch request present
//  br_ready     out  1       block can accept a request (high only in IDLE)
//  br_op        in   3       000 JZ, 001 JN, 010 JC, 011 JV, 100 JMP, 101 JNZ, 11x reserved
//  br_target    in   ADDR_W  branch destination
//  pc_load      out  1       one-cycle pulse: PC takes pc_target
//  pc_target    out  ADDR_W  registered destination, valid while pc_load=1
//  flush        out  1       squash fetched/decoded instructions
//  flag_clr     out  4       one-hot, one-cycle clear request to the flag register
//  op_err       out  1       one-cycle pulse: reserved op accepted
//  taken_cnt    out  16      taken-branch count (see CONFIGURATION)
//  ntaken_cnt   out  16      not-taken-branch count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except br_ready=1; latched op/target cleared; counters 0.
//  - Reset asserted mid-operation aborts immediately, asynchronously; no pending pulse survives.
//  - Handshake: transfer occurs when br_valid && br_ready (cycle T); op and target are latched.
//    With br_ready=0 the request is not latched and must be held by the source.
//  - FSM states:
//    IDLE    : on transfer -> RESOLVE.
//    RESOLVE : cycle T+1. Effective flags eff = alu_flag_en ? alu_flags : ccr_in, sampled in this cycle.
//              Conditions: JZ eff[0]; JN eff[1]; JC eff[2]; JV eff[3]; JMP always; JNZ !eff[0].
//              Taken -> FLUSH; not taken or reserved -> IDLE.
//    FLUSH   : flush=1 for exactly FLUSH_CYCLES cycles starting T+2, then -> IDLE; br_ready=1 from then.
//  - Outputs are registered; taken-branch pulses appear in cycle T+2:
//    pc_load=1 with pc_target=latched target;
//    flag_clr=tested bit for JZ/JN/JC/JV (when CLR_ON_TAKEN=1); JMP and JNZ never clear.
//  - Not-taken branch: no pc_load, no flush, no flag_clr; br_ready returns high at T+2.
//  - Reserved op: treated as not taken; op_err=1 in cycle T+2.
//  - Back-to-back: earliest next acceptance is T+2 (not taken) or T+2+FLUSH_CYCLES (taken).
//  - Forwarding: alu_flag_en high in the RESOLVE cycle overrides ccr_in for all four bits.
//    alu_flag_en in any other cycle has no effect on the decision.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//    - taken_cnt increments when RESOLVE decides taken.
//    - ntaken_cnt increments when RESOLVE decides not taken (reserved ops included).
//    - Both counters saturate at 16'hFFFF; both are cleared by rst.
//  BRANCH_STATS_EN undefined: counter logic is absent; taken_cnt and ntaken_cnt are constant 0.
// TESTING
//  1. rst high mid-FLUSH -> outputs 0 at once, br_ready=1; after release a JMP 8'h10 gives pc_load at T+2.
//  2. ccr_in=4'b0001, JZ target 8'h3C at T -> T+2: pc_load=1, pc_target=8'h3C, flag_clr=4'b0001;
//     flush=1 for T+2..T+3; br_ready=1 at T+4.
//  3. ccr_in=4'b0000, JC at T -> no pc_load/flush/flag_clr; br_ready=1 at T+2;
//     a second JMP at T+2 gives pc_load at T+4.
//  4. ccr_in=4'b0000, alu_flag_en=1, alu_flags=4'b0010 in RESOLVE cycle, JN -> taken, flag_clr=4'b0010;
//     same case with alu_flag_en=0 -> not taken.
//  5. br_op=3'b110 -> op_err pulse at T+2, no pc_load; br_valid held while br_ready=0 is not double-accepted.
//  6. BRANCH_STATS_EN defined: 3 taken + 2 not-taken -> taken_cnt=3, ntaken_cnt=2;
//     counter forced to 16'hFFFF stays at 16'hFFFF on the next taken branch.

Source files
------------

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl
//  Description : Conditional-branch resolver. Accepts one branch request,
//                evaluates it against the condition flags (forwarding ALU
//                flags written in the resolve cycle), redirects the PC,
//                flushes the front end for FLUSH_CYCLES cycles and pulses a
//                one-hot flag clear on a taken conditional branch.
//                Optional taken/not-taken statistics counters are built when
//                the BRANCH_STATS_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CLR_ON_TAKEN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ccr_in,
    input  logic [3:0]        alu_flags,
    input  logic              alu_flag_en,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_op,
    input  logic [ADDR_W-1:0] br_target,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic [3:0]        flag_clr,
    output logic              op_err,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       ntaken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESOLVE = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_flush_cnt;
    logic [3:0]          w_flush_cnt_nxt;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_target;
    logic [3:0]          w_eff;
    logic                w_cond;
    logic                w_reserved;
    logic                w_taken;
    logic                w_not_taken;
    logic [3:0]          w_clr;
    logic                r_ready;
    logic                r_pc_load;
    logic [ADDR_W-1:0]   r_pc_target;
    logic                r_flush;
    logic [3:0]          r_flag_clr;
    logic                r_op_err;

    // Branch condition evaluation; forwarded ALU flags win in the resolve cycle
    always_comb begin
        w_eff      = alu_flag_en ? alu_flags : ccr_in;
        w_reserved = (r_op[2:1] == 2'b11);
        case (r_op)
            3'b000:  w_cond = w_eff[0];
            3'b001:  w_cond = w_eff[1];
            3'b010:  w_cond = w_eff[2];
            3'b011:  w_cond = w_eff[3];
            3'b100:  w_cond = 1'b1;
            3'b101:  w_cond = ~w_eff[0];
            default: w_cond = 1'b0;
        endcase
        w_taken     = (r_state == S_RESOLVE) && w_cond;
        w_not_taken = (r_state == S_RESOLVE) && !w_cond;
        // Only the four single-flag tests clear the flag they consumed
        w_clr = 4'b0000;
        if ((CLR_ON_TAKEN != 0) && w_taken && !r_op[2])
            w_clr = 4'b0001 << r_op[1:0];
    end

    // Next-state and flush-length counter
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            S_IDLE: begin
                if (br_valid)
                    w_state_nxt = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (w_cond) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == 4'd0)
                    w_state_nxt = S_IDLE;
                else
                    w_flush_cnt_nxt = r_flush_cnt - 4'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Request latch; only an accepted request (IDLE with valid) is captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= 3'b000;
            r_target <= '0;
        end else if ((r_state == S_IDLE) && br_valid) begin
            r_op     <= br_op;
            r_target <= br_target;
        end
    end

    // Registered outputs; pulses land one cycle after the resolve decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready     <= 1'b1;
            r_pc_load   <= 1'b0;
            r_pc_target <= '0;
            r_flush     <= 1'b0;
            r_flag_clr  <= 4'b0000;
            r_op_err    <= 1'b0;
        end else begin
            r_ready    <= (w_state_nxt == S_IDLE);
            r_flush    <= (w_state_nxt == S_FLUSH);
            r_pc_load  <= w_taken;
            r_flag_clr <= w_clr;
            r_op_err   <= w_not_taken && w_reserved;
            if (w_taken)
                r_pc_target <= r_target;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_ntaken_cnt;

    // Saturating decision counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt  <= 16'h0000;
            r_ntaken_cnt <= 16'h0000;
        end else begin
            if (w_taken && (r_taken_cnt != 16'hFFFF))
                r_taken_cnt <= r_taken_cnt + 16'd1;
            if (w_not_taken && (r_ntaken_cnt != 16'hFFFF))
                r_ntaken_cnt <= r_ntaken_cnt + 16'd1;
        end
    end

    assign taken_cnt  = r_taken_cnt;
    assign ntaken_cnt = r_ntaken_cnt;
`else
    assign taken_cnt  = 16'h0000;
    assign ntaken_cnt = 16'h0000;
`endif

    assign br_ready  = r_ready;
    assign pc_load   = r_pc_load;
    assign pc_target = r_pc_target;
    assign flush     = r_flush;
    assign flag_clr  = r_flag_clr;
    assign op_err    = r_op_err;

endmodule
`default_nettype wire
